// File: rtl/if_id_decode_stage.sv
// if_id_decode_stage
// Fetch-to-decode pipeline register with a one-entry skid buffer.
// Words arrive over a valid/ready handshake. They leave in order as split
// decode fields. A flush empties the stage. A saturating counter records
// the cycles in which downstream held back a valid word.

module if_id_decode_stage #(
  parameter int INSTR_WIDTH     = 16,
  parameter int OPCODE_WIDTH    = 4,
  parameter int IMMEDIATE_WIDTH = INSTR_WIDTH - OPCODE_WIDTH,
  parameter int PC_WIDTH        = 16,
  parameter int CNT_WIDTH       = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [INSTR_WIDTH-1:0]     in_instr,
  input  logic [PC_WIDTH-1:0]        in_pc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [PC_WIDTH-1:0]        out_pc,
  output logic [OPCODE_WIDTH-1:0]    opcode,
  output logic [3:0]                 rd,
  output logic [3:0]                 rs,
  output logic [3:0]                 rt,
  output logic [IMMEDIATE_WIDTH-1:0] imm_field,
  output logic [CNT_WIDTH-1:0]       stall_cnt
);

  // Occupancy of the stage. EMPTY holds nothing. HOLD has a word only in
  // the output register. FULL also has a word in the skid register.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    HOLD  = 2'b01,
    FULL  = 2'b11
  } stage_state_t;

  stage_state_t state, next_state;

  logic [INSTR_WIDTH-1:0] out_instr_q;
  logic [PC_WIDTH-1:0]    out_pc_q;
  logic [INSTR_WIDTH-1:0] skid_instr_q;
  logic [PC_WIDTH-1:0]    skid_pc_q;

  logic accept;
  logic consume;
  logic load_out_from_in;
  logic load_out_from_skid;
  logic load_skid;
  logic skid_valid;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  // in_ready comes straight from registered state, so out_ready has no
  // combinational route to it. The handshakes are qualified by the
  // current occupancy.
  assign skid_valid = (state == FULL);
  assign out_valid  = (state != EMPTY);
  assign in_ready   = !skid_valid;
  assign accept     = in_valid && in_ready;
  assign consume    = out_valid && out_ready;

  // Occupancy register. Reset has priority over flush, and flush has
  // priority over any handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
    end else begin
      state <= next_state;
    end
  end

  // Next occupancy. A flush empties the stage, and any word offered in
  // the same cycle is dropped.
  always_comb begin
    next_state = state;
    if (flush) begin
      next_state = EMPTY;
    end else begin
      unique case (state)
        EMPTY: if (accept) next_state = HOLD;
        HOLD: begin
          if (consume && !accept) begin
            next_state = EMPTY;
          end else if (!consume && accept) begin
            next_state = FULL;
          end
        end
        FULL: if (consume) next_state = HOLD;
        default: next_state = EMPTY;
      endcase
    end
  end

  // Datapath steering. A new word goes to the output register when that
  // register is free or being drained. Otherwise the new word goes to the
  // skid register. The skid word moves forward once the output word is
  // consumed.
  always_comb begin
    load_out_from_in   = 1'b0;
    load_out_from_skid = 1'b0;
    load_skid          = 1'b0;
    if (!flush) begin
      unique case (state)
        EMPTY: load_out_from_in = accept;
        HOLD: begin
          load_out_from_in = accept && consume;
          load_skid        = accept && !consume;
        end
        FULL: load_out_from_skid = consume;
        default: ;
      endcase
    end
  end

  // Output and skid data registers. These are cleared only by reset.
  // A flush leaves their contents in place and marks them invalid.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_instr_q  <= '0;
      out_pc_q     <= '0;
      skid_instr_q <= '0;
      skid_pc_q    <= '0;
    end else begin
      if (load_out_from_in) begin
        out_instr_q <= in_instr;
        out_pc_q    <= in_pc;
      end else if (load_out_from_skid) begin
        out_instr_q <= skid_instr_q;
        out_pc_q    <= skid_pc_q;
      end
      if (load_skid) begin
        skid_instr_q <= in_instr;
        skid_pc_q    <= in_pc;
      end
    end
  end

  // Back-pressure counter. It counts cycles in which downstream refuses a
  // valid word, ignores flush cycles, and stops at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && !flush && (stall_cnt != CNT_MAX)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  // Decode fields are plain slices of the output register.
  assign out_pc    = out_pc_q;
  assign opcode    = out_instr_q[INSTR_WIDTH-1 -: OPCODE_WIDTH];
  assign rd        = out_instr_q[11:8];
  assign rs        = out_instr_q[7:4];
  assign rt        = out_instr_q[3:0];
  assign imm_field = out_instr_q[IMMEDIATE_WIDTH-1:0];

endmodule

// File: tb/tb_if_id_decode_stage.sv
// tb_if_id_decode_stage
// Directed tests of the fetch-to-decode stage cover reset, streaming,
// back-pressure, flush and the stall counter. A second instance uses a
// 3-bit counter so that saturation is reached quickly. A random
// valid/ready phase then compares the stage against a queue model.

module tb_if_id_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_instr;
  logic [15:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_pc;
  logic [3:0]  opcode;
  logic [3:0]  rd;
  logic [3:0]  rs;
  logic [3:0]  rt;
  logic [11:0] imm_field;
  logic [15:0] stall_cnt;

  logic        s_in_ready;
  logic        s_out_valid;
  logic [15:0] s_out_pc;
  logic [3:0]  s_opcode;
  logic [3:0]  s_rd;
  logic [3:0]  s_rs;
  logic [3:0]  s_rt;
  logic [11:0] s_imm_field;
  logic [2:0]  s_stall_cnt;

  int errors = 0;
  int checks = 0;

  logic [31:0] model_q[$];
  logic [15:0] next_pc;
  logic [15:0] rand_word;
  logic        model_accept;
  logic        model_consume;

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  if_id_decode_stage dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .in_pc     (in_pc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .opcode    (opcode),
    .rd        (rd),
    .rs        (rs),
    .rt        (rt),
    .imm_field (imm_field),
    .stall_cnt (stall_cnt)
  );

  if_id_decode_stage #(.CNT_WIDTH(3)) dut_small (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (s_in_ready),
    .in_instr  (in_instr),
    .in_pc     (in_pc),
    .out_valid (s_out_valid),
    .out_ready (out_ready),
    .out_pc    (s_out_pc),
    .opcode    (s_opcode),
    .rd        (s_rd),
    .rs        (s_rs),
    .rt        (s_rt),
    .imm_field (s_imm_field),
    .stall_cnt (s_stall_cnt)
  );

  task automatic applyStimulus(input logic r, input logic f, input logic iv,
                               input logic [15:0] instr, input logic [15:0] pc,
                               input logic ordy);
    rst       = r;
    flush     = f;
    in_valid  = iv;
    in_instr  = instr;
    in_pc     = pc;
    out_ready = ordy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
    tick();
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);
    tick();
    checkOutput("init_out_valid", 32'(out_valid), 32'd0);
    checkOutput("init_in_ready",  32'(in_ready),  32'd1);

    $display("[TB] streaming");
    applyStimulus(1'b0, 1'b0, 1'b1, 16'hA3F7, 16'h0010, 1'b1);
    tick();
    checkOutput("str1_valid",  32'(out_valid), 32'd1);
    checkOutput("str1_opcode", 32'(opcode),    32'hA);
    checkOutput("str1_rd",     32'(rd),        32'h3);
    checkOutput("str1_rs",     32'(rs),        32'hF);
    checkOutput("str1_rt",     32'(rt),        32'h7);
    checkOutput("str1_imm",    32'(imm_field), 32'h3F7);
    checkOutput("str1_pc",     32'(out_pc),    32'h0010);
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h1234, 16'h0012, 1'b1);
    tick();
    checkOutput("str2_valid",  32'(out_valid), 32'd1);
    checkOutput("str2_opcode", 32'(opcode),    32'h1);
    checkOutput("str2_imm",    32'(imm_field), 32'h234);
    checkOutput("str2_pc",     32'(out_pc),    32'h0012);
    checkOutput("str2_ready",  32'(in_ready),  32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);
    tick();
    checkOutput("str_drained", 32'(out_valid), 32'd0);
    checkOutput("str_stall",   32'(stall_cnt), 32'd0);

    $display("[TB] back-pressure");
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h1111, 16'h0020, 1'b0);
    tick();
    checkOutput("bp1_valid", 32'(out_valid), 32'd1);
    checkOutput("bp1_ready", 32'(in_ready),  32'd1);
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h2222, 16'h0022, 1'b0);
    tick();
    checkOutput("bp2_ready", 32'(in_ready),  32'd0);
    checkOutput("bp2_pc",    32'(out_pc),    32'h0020);
    checkOutput("bp2_stall", 32'(stall_cnt), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h4444, 16'h0024, 1'b0);
    tick();
    checkOutput("bp3_held_opcode", 32'(opcode),    32'h1);
    checkOutput("bp3_held_imm",    32'(imm_field), 32'h111);
    checkOutput("bp3_ready",       32'(in_ready),  32'd0);
    checkOutput("bp3_stall",       32'(stall_cnt), 32'd2);
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h4444, 16'h0024, 1'b1);
    tick();
    checkOutput("bp4_pc",    32'(out_pc),    32'h0022);
    checkOutput("bp4_imm",   32'(imm_field), 32'h222);
    checkOutput("bp4_ready", 32'(in_ready),  32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);
    tick();
    checkOutput("bp5_empty", 32'(out_valid), 32'd0);

    $display("[TB] flush");
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h5555, 16'h0030, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h6666, 16'h0032, 1'b0);
    tick();
    checkOutput("fl_full_ready", 32'(in_ready),  32'd0);
    checkOutput("fl_full_stall", 32'(stall_cnt), 32'd3);
    applyStimulus(1'b0, 1'b1, 1'b1, 16'h3333, 16'h0034, 1'b0);
    tick();
    checkOutput("fl_valid",  32'(out_valid), 32'd0);
    checkOutput("fl_ready",  32'(in_ready),  32'd1);
    checkOutput("fl_stall",  32'(stall_cnt), 32'd3);
    checkOutput("fl_pc_kept", 32'(out_pc),   32'h0030);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);
    tick();
    checkOutput("fl_no_3333", 32'(out_valid), 32'd0);

    $display("[TB] reset while full");
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h8888, 16'h0040, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h9999, 16'h0042, 1'b0);
    tick();
    checkOutput("rst_pre_ready", 32'(in_ready), 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b1, 16'hBBBB, 16'h0044, 1'b1);
    tick();
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
    checkOutput("rst_valid",  32'(out_valid), 32'd0);
    checkOutput("rst_ready",  32'(in_ready),  32'd1);
    checkOutput("rst_stall",  32'(stall_cnt), 32'd0);
    checkOutput("rst_imm",    32'(imm_field), 32'd0);
    checkOutput("rst_opcode", 32'(opcode),    32'd0);
    checkOutput("rst_pc",     32'(out_pc),    32'd0);

    $display("[TB] stall counter");
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h7777, 16'h0050, 1'b0);
    tick();
    checkOutput("st_start", 32'(stall_cnt), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
    for (int i = 0; i < 5; i++) tick();
    checkOutput("st_five",       32'(stall_cnt),   32'd5);
    checkOutput("st_small_five", 32'(s_stall_cnt), 32'd5);
    for (int i = 0; i < 5; i++) tick();
    checkOutput("st_ten",       32'(stall_cnt),   32'd10);
    checkOutput("st_small_sat", 32'(s_stall_cnt), 32'd7);
    tick();
    checkOutput("st_small_hold",  32'(s_stall_cnt), 32'd7);
    checkOutput("st_eleven",      32'(stall_cnt),   32'd11);
    checkOutput("st_stable_pc",   32'(out_pc),      32'h0050);
    checkOutput("st_stable_imm",  32'(imm_field),   32'h777);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);
    tick();
    checkOutput("st_drained", 32'(out_valid), 32'd0);
    checkOutput("st_frozen",  32'(stall_cnt), 32'd11);

    $display("[TB] random valid/ready");
    model_q.delete();
    next_pc = 16'h1000;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      checkOutput("rnd_valid", 32'(out_valid), 32'(model_q.size() > 0));
      checkOutput("rnd_ready", 32'(in_ready),  32'(model_q.size() < 2));
      if (model_q.size() > 0) begin
        checkOutput("rnd_data", {opcode, rd, rs, rt, out_pc}, model_q[0]);
      end
      rand_word = 16'($urandom);
      applyStimulus(1'b0, ($urandom_range(0, 49) == 0), 1'($urandom_range(0, 1)),
                    rand_word, next_pc, 1'($urandom_range(0, 1)));
      #1;
      checkOutput("rnd_ready_indep", 32'(in_ready), 32'(model_q.size() < 2));
      if (flush) begin
        model_q.delete();
      end else begin
        model_accept  = in_valid && (model_q.size() < 2);
        model_consume = out_ready && (model_q.size() > 0);
        if (model_consume) void'(model_q.pop_front());
        if (model_accept) begin
          model_q.push_back({in_instr, in_pc});
          next_pc = next_pc + 16'd2;
        end
      end
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
